// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl -- MEM-stage data memory access controller for an RV32I pipeline.
//
// Accepts one load or store from the MEM stage, stalls the pipeline while the
// access is in flight, and talks to a ready/rvalid style memory port. Stores
// are lane-replicated with byte enables; loads are lane-selected and sign- or
// zero-extended. An access that spends MAX_WAIT cycles in REQ plus RESP is
// abandoned and reported with o_timeout alongside o_done.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid             MEM-stage instruction valid
//   i_mem_read/write    load / store request (read wins when both set)
//   i_funct3            RV32I size code (B, H, W, BU, HU)
//   i_addr, i_wdata     byte address, low-aligned store data
//   o_stall             hold pipeline at and before MEM
//   o_done              one-cycle completion pulse
//   o_mem_data_out      extended load result (held between loads)
//   o_misaligned        current op is misaligned or has an illegal funct3
//   o_timeout           access abandoned (pulses with o_done)
//   o_req, o_we         memory request / write enable
//   o_addr              word address
//   o_wdata, o_wmask    replicated store data / byte enables
//   i_ready             memory accepts the request this cycle
//   i_rvalid, i_rdata   read response
// ---------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_mem_data_out,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic        o_req,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wmask,
  input  logic        i_ready,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter value seen on the last permitted REQ/RESP cycle.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_is_load;
  logic        r_timeout;
  logic [31:0] r_load_data;

  logic        w_op;
  logic        w_bad;
  logic        w_start;
  logic        w_expire;
  logic        w_set_timeout;
  logic        w_load_done;
  logic        w_in_req;
  logic        w_store_req;
  logic [31:0] w_wdata_rep;
  logic [3:0]  w_wmask;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  assign w_op = i_valid & (i_mem_read | i_mem_write);

  // Alignment / legality of the op currently presented by the MEM stage.
  always_comb begin : align_check
    w_bad = 1'b0;
    case (i_funct3)
      3'b000, 3'b100: w_bad = 1'b0;
      3'b001, 3'b101: w_bad = i_addr[0];
      3'b010:         w_bad = |i_addr[1:0];
      default:        w_bad = 1'b1;
    endcase
  end

  assign w_start  = (r_state == ST_IDLE) & w_op & ~w_bad;
  assign w_expire = (r_wait_cnt == LAST_WAIT);

  // Next state. A completing event on the last permitted cycle wins over the
  // timeout; a load accepted on that cycle cannot finish in time and expires.
  always_comb begin : next_state
    w_state_next  = r_state;
    w_set_timeout = 1'b0;
    w_load_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_ready & ~r_is_load) begin
          w_state_next = ST_DONE;
        end else if (w_expire) begin
          w_state_next  = ST_DONE;
          w_set_timeout = 1'b1;
        end else if (i_ready) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rvalid) begin
          w_state_next = ST_DONE;
          w_load_done  = 1'b1;
        end else if (w_expire) begin
          w_state_next  = ST_DONE;
          w_set_timeout = 1'b1;
        end
      end
      ST_DONE: begin
        // Never restarts here: the op still on the inputs is the one just
        // finished, the pipeline advances on this cycle's o_done.
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 8'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_funct3    <= 3'd0;
      r_is_load   <= 1'b0;
      r_timeout   <= 1'b0;
      r_load_data <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_addr     <= i_addr;
        r_wdata    <= i_wdata;
        r_funct3   <= i_funct3;
        r_is_load  <= i_mem_read;
        r_wait_cnt <= 8'd0;
        r_timeout  <= 1'b0;
      end else if ((r_state == ST_REQ) || (r_state == ST_RESP)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
      if (w_load_done) begin
        r_load_data <= w_load_ext;
      end
    end
  end

  // Store lane replication and byte enables from the latched op.
  always_comb begin : store_lanes
    w_wdata_rep = r_wdata;
    w_wmask     = 4'b1111;
    case (r_funct3[1:0])
      2'b00: begin
        w_wdata_rep = {4{r_wdata[7:0]}};
        w_wmask     = 4'b0001 << r_addr[1:0];
      end
      2'b01: begin
        w_wdata_rep = {2{r_wdata[15:0]}};
        w_wmask     = 4'b0011 << r_addr[1:0];
      end
      default: begin
        w_wdata_rep = r_wdata;
        w_wmask     = 4'b1111;
      end
    endcase
  end

  // Load lane select and extension.
  always_comb begin : load_extract
    case (r_addr[1:0])
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = r_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = i_rdata;
    endcase
  end

  // Every output is forced low while reset is asserted.
  assign w_in_req    = (r_state == ST_REQ) & ~i_rst;
  assign w_store_req = w_in_req & ~r_is_load;

  assign o_req          = w_in_req;
  assign o_we           = w_store_req;
  assign o_addr         = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign o_wdata        = w_store_req ? w_wdata_rep : 32'd0;
  assign o_wmask        = w_store_req ? w_wmask : 4'd0;
  assign o_stall        = ~i_rst & (w_start | (r_state == ST_REQ) | (r_state == ST_RESP));
  assign o_done         = ~i_rst & (r_state == ST_DONE);
  assign o_timeout      = ~i_rst & (r_state == ST_DONE) & r_timeout;
  assign o_misaligned   = ~i_rst & (r_state == ST_IDLE) & w_op & w_bad;
  assign o_mem_data_out = i_rst ? 32'd0 : r_load_data;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: MAX_WAIT, 255, max cycles spent in REQ plus RESP before the access is abandoned; range 1..255.
REQ-002 One clock; reset is synchronous and active-high. Clock port i_clk, reset port i_rst.
REQ-003 i_clk  in  1  clock; all state changes on the rising edge.
REQ-004 i_rst  in  1  synchronous active-high reset.
REQ-005 i_valid  in  1  MEM-stage instruction valid.
REQ-006 i_mem_read / i_mem_write  in  1 each  load / store request.
REQ-007 i_funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 i_addr  in  32  byte address.
REQ-009 i_wdata  in  32  store data, low-aligned.
REQ-010 o_stall  out  1  freeze pipeline at and before MEM.
REQ-011 o_done  out  1  one-cycle pulse; access completed; MEM/WB captures this cycle.
REQ-012 o_mem_data_out  out  32  extended load result, feeds MEM/WB mem data input.
REQ-013 o_misaligned  out  1  combinational; current op is misaligned or has an illegal funct3.
REQ-014 o_timeout  out  1  one-cycle pulse with o_done when the access was abandoned.
REQ-015 o_req, o_we  out  1 each  memory request, write enable.
REQ-016 o_addr  out  32  word address (i_addr with bits [1:0] forced to 00).
REQ-017 o_wdata  out  32; o_wmask  out  4  byte-replicated store data and byte enables.
REQ-018 i_ready  in  1  memory accepts the request this cycle.
REQ-019 i_rvalid  in  1; i_rdata  in  32  read response valid and data.

Function
REQ-020 FSM states: IDLE, REQ, RESP, DONE.
REQ-021 Op present: i_valid & (i_mem_read | i_mem_write). Read wins when both are set; the store is dropped.
REQ-022 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0. Illegal: funct3 in {011,110,111}. In either case, in IDLE: o_misaligned=1, no request, o_stall=0, state stays IDLE.
REQ-023 IDLE with a legal op present: o_stall=1 (combinational); latch addr, wdata, funct3, and kind; go to REQ; wait counter cleared.
REQ-024 REQ: o_req=1, o_stall=1, o_addr/o_we/o_wdata/o_wmask driven from latched values and held stable until i_ready=1.
REQ-025 REQ with i_ready=1: store goes to DONE; load goes to RESP.
REQ-026 i_rvalid is ignored outside RESP.
REQ-027 RESP: o_req=0, o_stall=1. On i_rvalid=1, register the extracted data into o_mem_data_out and go to DONE.
REQ-028 DONE: o_done=1, o_stall=0, then IDLE. The same op still present in DONE is not restarted.
REQ-029 Minimum MEM occupancy is 3 cycles for a store (IDLE, REQ, DONE) and 4 for a load when ready and rvalid each arrive immediately.
REQ-030 Wait counter increments each cycle in REQ/RESP. When it reaches MAX_WAIT: go to DONE with o_timeout=1, o_mem_data_out unchanged, o_req dropped.
REQ-031 Store mask: SB 0001<<addr[1:0] with the byte replicated x4; SH 0011<<addr[1:0] with the half replicated x2; SW 1111.
REQ-032 Load extract: select the byte/half by addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-033 o_mem_data_out holds its value except on a load completion.
REQ-034 o_req, o_we, o_addr, o_wdata, and o_wmask are 0 in IDLE, RESP, and DONE.

Reset
REQ-035 On the i_rst edge: state=IDLE, counter=0, o_mem_data_out=0. All outputs are 0 in the reset cycle.
REQ-036 Reset in REQ/RESP abandons the access: no o_done, o_req=0 next cycle, and a late i_rvalid is ignored.
REQ-037 Reset takes priority over every other transition.

Verification
REQ-038 LW addr 0x100, i_ready and i_rvalid immediate, rdata 0xDEADBEEF -> o_stall high 3 cycles; o_done in cycle 4; o_mem_data_out=0xDEADBEEF.
REQ-039 LB addr 0x103, rdata 0x80FF_1234 -> 0xFFFFFF80. LBU same access -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
REQ-040 SB addr 0x201, wdata 0x000000AB, i_ready held low 5 cycles -> o_req held with o_addr 0x200, o_wmask 0010, o_wdata 0xABABABAB, all stable; o_done 1 cycle after ready.
REQ-041 LH addr 0x101 -> o_misaligned=1, o_req never asserted, o_stall=0.
REQ-042 MAX_WAIT=4, i_ready never asserted -> o_timeout and o_done pulse together, o_mem_data_out unchanged, FSM returns to IDLE.
REQ-043 i_rst asserted in RESP, then i_rvalid=1 -> no o_done, o_mem_data_out=0, state IDLE.
